cdc_toggle_rx: RTL and testbench
================================

Name: cdc_toggle_rx

Overview:
- Receive end of a toggle-handshake clock-domain crossing.
- A transmitter in a foreign clock domain presents a data word and flips req_tgl. This block synchronizes req_tgl into clk, captures the word and returns ack_tgl.
- The word is presented downstream on a valid/ready interface.
- Used wherever multi-bit values (counter snapshots, config words) cross into the pulse-sequencer domain, where a single flop is not sufficient.

Parameters:
WIDTH, 32, data word width.
SYNC_STAGES, 2, synchronizer flops on req_tgl; legal values are 2 or more.

Ports:
clk  input  1  sole clock; all state updates on posedge clk.
rst  input  1  synchronous, active-high reset.
req_tgl  input  1  request toggle from the transmitter domain; asynchronous to clk.
data_in  input  WIDTH  transmitter data; held stable by the transmitter while req_tgl != ack_tgl.
ack_tgl  output  1  acknowledge toggle back to the transmitter; registered.
dout  output  WIDTH  captured word; registered.
dout_valid  output  1  dout holds an unconsumed word.
dout_ready  input  1  downstream accepts dout when dout_valid && dout_ready.
busy  output  1  a request is synchronized but not yet captured (req_s != ack_tgl).
err_stable  output  1  sticky data-stability error; tied 0 unless the optional feature is compiled in.

Behaviour:
- Synchronizer: req_tgl passes through SYNC_STAGES flops, all reset to 0. The last stage is req_s. No logic sits between stages.
- pending = (req_s != ack_tgl). busy = pending, registered-equivalent (both operands are registered).
- Capture condition: pending && (!dout_valid || dout_ready).
- On a capture cycle:
  - dout <= data_in
  - dout_valid <= 1
  - ack_tgl <= ~ack_tgl
- Accept without capture: dout_valid && dout_ready && !capture gives dout_valid <= 0; dout holds its last value.
- Simultaneous accept and pending: capture the new word and keep dout_valid at 1. This supports back-to-back transfers with no bubble.
- Backpressure: while dout_valid && !dout_ready, no capture occurs. ack_tgl is therefore not toggled, and the transmitter holds data_in. No overflow is possible and no word is dropped.
- Latency (macro off):
  - req_tgl edge to dout_valid is SYNC_STAGES+1 clk cycles, given an empty output and a setup-met edge.
  - ack_tgl toggles in the same cycle dout_valid rises.
- ack_tgl toggles exactly once per captured word and never toggles without a capture.
- Data is sampled only once req_s has changed. The transmitter guarantees data_in stable from before its req edge until it observes ack. No per-bit synchronization of data_in.
- Reset (any cycle, including mid-transfer or with dout_valid=1):
  - Next cycle: sync chain, ack_tgl, dout_valid and err_stable are 0; dout is 0.
  - The in-flight word is discarded.
  - Both ends must be reset together. If req_tgl is 1 after rst deasserts, it is treated as one new request.
- dout_ready while dout_valid=0 is ignored.

Optional Feature:
Macro: CDC_TOGGLE_RX_STABILITY_CHECK_EN
- Defined:
  - Capture becomes two cycles. The cycle in which the capture condition first holds registers data_in into a shadow register (state SAMPLE); ack_tgl is not toggled yet.
  - The next cycle compares data_in to the shadow and performs the capture as above, loading the second sample.
  - A mismatch sets err_stable=1, which stays set until rst.
  - Latency becomes SYNC_STAGES+2.
  - The accept/capture overlap still applies: the SAMPLE cycle may overlap a held dout_valid only if dout_ready is high in the completing cycle; otherwise it stays in SAMPLE and re-samples.
- Undefined: no shadow register; err_stable is a constant 0; the latency above applies.

Test Plan:
- Reset: rst=1 for 3 cycles with req_tgl=0 -> dout_valid=0, ack_tgl=0, dout=0, busy=0, err_stable=0.
- Single transfer (SYNC_STAGES=2): data_in=0xDEADBEEF, req_tgl 0->1 at cycle 0, dout_ready=1 -> cycle 3: dout_valid=1, dout=0xDEADBEEF, ack_tgl=1; cycle 4: dout_valid=0.
- Backpressure: dout_ready=0, transmitter sends 0x1 then 0x2 -> dout=0x1 valid, ack_tgl=1, busy=1 and ack holds while second request pending. Pulse dout_ready for 1 cycle -> next cycle dout=0x2, dout_valid stays 1, ack_tgl=0, busy=0.
- Reset mid-operation: dout_valid=1 with dout=0x55 and a second request pending, assert rst for 1 cycle -> dout_valid=0, ack_tgl=0. After release with req_tgl=0, no transfer occurs.
- Latency sweep: SYNC_STAGES=3 -> dout_valid rises 4 cycles after the req_tgl edge (5 with macro defined).
- Macro defined: data_in changes 0xA->0xB between SAMPLE and capture cycles -> err_stable=1 (sticky), dout=0xB. Same stimulus with macro undefined -> err_stable=0, dout=0xA.

Source files
------------

// File: rtl/cdc_toggle_rx.sv
// Receive end of a toggle-handshake clock-domain crossing.
// A foreign-domain transmitter flips req_tgl with data_in held stable. This block synchronizes
// req_tgl, captures data_in once the synchronized request differs from ack_tgl, returns ack_tgl
// and presents the captured word on a valid/ready interface.
// Optional build macro CDC_TOGGLE_RX_STABILITY_CHECK_EN: capture takes two cycles (sample into a
// shadow register, then compare and capture), and err_stable flags words that changed between them.
module cdc_toggle_rx #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_tgl,
    input  logic [WIDTH-1:0] data_in,
    output logic             ack_tgl,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             err_stable
);

    // Synchronizer chain; the last stage is the only one used by logic.
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;

    // Output-side state.
    logic             ack_q,   ack_d;
    logic [WIDTH-1:0] dout_q,  dout_d;
    logic             valid_q, valid_d;

    // Decoded control.
    logic pending;
    logic out_free;
    logic capture;

    assign req_s    = sync_q[SYNC_STAGES-1];
    assign pending  = req_s ^ ack_q;
    // Output register can take a new word: empty, or being drained this cycle.
    assign out_free = !valid_q || dout_ready;

    // Plain shift chain on req_tgl, no logic between stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], req_tgl};
        end
    end

`ifdef CDC_TOGGLE_RX_STABILITY_CHECK_EN

    typedef enum logic [0:0] {
        StIdle,
        StSample
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shadow_q;
    logic             sample_en;
    logic             err_q, err_d;

    // Two-step capture: first sample into the shadow, then compare and capture.
    always_comb begin
        state_d   = state_q;
        capture   = 1'b0;
        sample_en = 1'b0;
        err_d     = err_q;
        unique case (state_q)
            StIdle: begin
                if (pending && out_free) begin
                    sample_en = 1'b1;
                    state_d   = StSample;
                end
            end
            StSample: begin
                if (out_free) begin
                    capture = 1'b1;
                    state_d = StIdle;
                    if (data_in != shadow_q) begin
                        err_d = 1'b1;
                    end
                end else begin
                    // Output still blocked: refresh the sample and try again next cycle.
                    sample_en = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state, shadow sample and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            shadow_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if (sample_en) begin
                shadow_q <= data_in;
            end
        end
    end

    assign err_stable = err_q;

`else

    // Single-cycle capture as soon as a request is seen and the output can take it.
    assign capture    = pending && out_free;
    assign err_stable = 1'b0;

`endif

    // Next-state for the output register, valid flag and acknowledge toggle.
    always_comb begin
        ack_d   = ack_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        if (capture) begin
            // Covers the back-to-back case: valid stays high while the new word replaces the old.
            dout_d  = data_in;
            valid_d = 1'b1;
            ack_d   = ~ack_q;
        end else if (valid_q && dout_ready) begin
            valid_d = 1'b0;
        end
    end

    // Output-side registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q   <= 1'b0;
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            ack_q   <= ack_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
        end
    end

    assign ack_tgl    = ack_q;
    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign busy       = pending;

endmodule

// File: tb/tb_cdc_toggle_rx.sv
// Directed bench for cdc_toggle_rx: one instance with SYNC_STAGES=2, one with SYNC_STAGES=3.
// Expected values adapt to the optional CDC_TOGGLE_RX_STABILITY_CHECK_EN build.
module tb_cdc_toggle_rx;

`ifdef CDC_TOGGLE_RX_STABILITY_CHECK_EN
    localparam int Extra = 1;
`else
    localparam int Extra = 0;
`endif
    localparam int Sync  = 2;
    localparam int Lat   = Sync + 1 + Extra;
    localparam int Lat3  = 3 + 1 + Extra;

    logic        clk;
    logic        rst;
    logic        req_tgl;
    logic        req3;
    logic [31:0] data_in;
    logic        dout_ready;

    logic        ack_tgl,  ack3;
    logic [31:0] dout,     dout3;
    logic        dout_valid, valid3;
    logic        busy,     busy3;
    logic        err_stable, err3;

    int n_checks = 0;
    int n_errors = 0;

    cdc_toggle_rx #(
        .WIDTH       (32),
        .SYNC_STAGES (Sync)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .req_tgl    (req_tgl),
        .data_in    (data_in),
        .ack_tgl    (ack_tgl),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .err_stable (err_stable)
    );

    cdc_toggle_rx #(
        .WIDTH       (32),
        .SYNC_STAGES (3)
    ) u_dut3 (
        .clk        (clk),
        .rst        (rst),
        .req_tgl    (req3),
        .data_in    (data_in),
        .ack_tgl    (ack3),
        .dout       (dout3),
        .dout_valid (valid3),
        .dout_ready (dout_ready),
        .busy       (busy3),
        .err_stable (err3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        req_tgl    = 1'b0;
        req3       = 1'b0;
        data_in    = '0;
        dout_ready = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_valid", dout_valid, 0);
        check("rst_ack",   ack_tgl,    0);
        check("rst_dout",  dout,       0);
        check("rst_busy",  busy,       0);
        check("rst_err",   err_stable, 0);
        rst = 1'b0;

        // Single transfer
        data_in    = 32'hDEADBEEF;
        dout_ready = 1'b1;
        req_tgl    = 1'b1;
        repeat (Lat - 1) tick();
        check("st_valid_early", dout_valid, 0);
        check("st_ack_early",   ack_tgl,    0);
        check("st_busy_early",  busy,       1);
        tick();
        check("st_valid", dout_valid, 1);
        check("st_dout",  dout,       32'hDEADBEEF);
        check("st_ack",   ack_tgl,    1);
        check("st_busy",  busy,       0);
        tick();
        check("st_drain_valid", dout_valid, 0);
        check("st_drain_dout",  dout,       32'hDEADBEEF);

        // Fresh start for backpressure
        dout_ready = 1'b0;
        req_tgl    = 1'b0;
        rst        = 1'b1;
        tick();
        rst = 1'b0;

        // Backpressure: word 1 held, word 2 waits
        data_in = 32'h1;
        req_tgl = 1'b1;
        repeat (Lat) tick();
        check("bp_w1_valid", dout_valid, 1);
        check("bp_w1_dout",  dout,       32'h1);
        check("bp_w1_ack",   ack_tgl,    1);
        data_in = 32'h2;
        req_tgl = 1'b0;
        repeat (Sync + 3) tick();
        check("bp_hold_dout",  dout,       32'h1);
        check("bp_hold_valid", dout_valid, 1);
        check("bp_hold_ack",   ack_tgl,    1);
        check("bp_hold_busy",  busy,       1);
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        repeat (Extra) tick();
        check("bp_w2_dout",  dout,       32'h2);
        check("bp_w2_valid", dout_valid, 1);
        check("bp_w2_ack",   ack_tgl,    0);
        check("bp_w2_busy",  busy,       0);

        // Reset mid-operation: 0x55 held, 0x66 pending
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        check("mr_drained", dout_valid, 0);
        data_in = 32'h55;
        req_tgl = 1'b1;
        repeat (Lat) tick();
        check("mr_dout55", dout,    32'h55);
        check("mr_ack1",   ack_tgl, 1);
        data_in = 32'h66;
        req_tgl = 1'b0;
        repeat (Sync + 1) tick();
        check("mr_busy", busy, 1);
        rst = 1'b1;
        tick();
        check("mr_rst_valid", dout_valid, 0);
        check("mr_rst_ack",   ack_tgl,    0);
        check("mr_rst_dout",  dout,       0);
        rst = 1'b0;
        repeat (6) tick();
        check("mr_idle_valid", dout_valid, 0);
        check("mr_idle_ack",   ack_tgl,    0);
        check("mr_idle_busy",  busy,       0);

        // Latency sweep on the SYNC_STAGES=3 instance
        data_in    = 32'h33;
        dout_ready = 1'b1;
        req3       = 1'b1;
        repeat (Lat3 - 1) tick();
        check("l3_valid_early", valid3, 0);
        tick();
        check("l3_valid", valid3, 1);
        check("l3_dout",  dout3,  32'h33);
        check("l3_ack",   ack3,   1);

        // Data changes between the sample and capture cycles
        data_in = 32'hA;
        req_tgl = 1'b1;
        repeat (Sync + 1) tick();
        data_in = 32'hB;
        repeat (Extra) tick();
`ifdef CDC_TOGGLE_RX_STABILITY_CHECK_EN
        check("stab_err",  err_stable, 1);
        check("stab_dout", dout,       32'hB);
        tick();
        check("stab_err_sticky", err_stable, 1);
`else
        check("stab_err",  err_stable, 0);
        check("stab_dout", dout,       32'hA);
        tick();
        check("stab_err_sticky", err_stable, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
